cmp_eqge_serial: RTL and testbench

//  Digit-serial EQ/GE comparator, scanning MSB-first with early termination.

---
 rtl/cmp_eqge_serial.sv | 222 ++++++++++++++++++++++
 tb/tb_cmp_eqge_serial.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_eqge_serial.sv
// Digit-serial EQ/GE comparator: scans operands MSB-first one digit per cycle and stops at the first differing digit.
// Optional build macro CMP_SERIAL_SIGNED_EN selects a two's-complement compare; the default build compares unsigned.

// Single-cycle EQ/GE of two digit-wide operands; speed 0 ripples LSB-to-MSB, otherwise a log-depth prefix tree.
module CmpEQGE #(
  parameter int unsigned width = 8,
  parameter int unsigned speed = 2
) (
  input  logic [width-1:0] A_i,
  input  logic [width-1:0] B_i,
  output logic             EQ_o,
  output logic             GE_o
);

  logic [width-1:0] bit_eq;
  logic [width-1:0] bit_gt;

  assign bit_eq = ~(A_i ^ B_i);
  assign bit_gt = A_i & ~B_i;

  if (speed == 0) begin : g_ripple
    logic eq_acc;
    logic gt_acc;

    // A higher bit that differs overrides whatever the lower bits decided.
    always_comb begin
      eq_acc = 1'b1;
      gt_acc = 1'b0;
      for (int i = 0; i < int'(width); i++) begin
        gt_acc = bit_gt[i] | (bit_eq[i] & gt_acc);
        eq_acc = eq_acc & bit_eq[i];
      end
    end

    assign EQ_o = eq_acc;
    assign GE_o = gt_acc | eq_acc;
  end else begin : g_tree
    // Only the whole-word prefix is needed, so both parallel styles collapse to one balanced tree.
    localparam int unsigned leaves = (width <= 1) ? 1 : (32'd1 << $clog2(width));
    localparam int unsigned nodes  = 2 * leaves - 1;

    logic [nodes-1:0] t_eq;
    logic [nodes-1:0] t_gt;

    // Heap layout: node k has children 2k+1 (less significant) and 2k+2; pad leaves are neutral.
    always_comb begin
      t_eq = '1;
      t_gt = '0;
      for (int i = 0; i < int'(leaves); i++) begin
        if (i < int'(width)) begin
          t_eq[int'(leaves) - 1 + i] = bit_eq[i];
          t_gt[int'(leaves) - 1 + i] = bit_gt[i];
        end
      end
      for (int k = int'(leaves) - 2; k >= 0; k--) begin
        t_eq[k] = t_eq[2*k+2] & t_eq[2*k+1];
        t_gt[k] = t_gt[2*k+2] | (t_eq[2*k+2] & t_gt[2*k+1]);
      end
    end

    assign EQ_o = t_eq[0];
    assign GE_o = t_gt[0] | t_eq[0];
  end

endmodule

module cmp_eqge_serial #(
  parameter int unsigned width = 32,
  parameter int unsigned digit = 8,
  parameter int unsigned speed = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] A_i,
  input  logic [width-1:0] B_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             EQ_o,
  output logic             GE_o,
  output logic             busy_o
);

  localparam int unsigned digit_safe = (digit < 1) ? 1 : digit;
  localparam int unsigned n_dig      = width / digit_safe;
  localparam int unsigned cnt_w      = (n_dig > 1) ? $clog2(n_dig) : 1;

  if ((digit < 1) || (digit > width) || ((width % digit_safe) != 0)) begin : g_param_check
    $fatal(1, "cmp_eqge_serial: width must be a nonzero multiple of digit");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [width-1:0] a_q;
  logic [width-1:0] b_q;
  logic [cnt_w-1:0] cnt_q;

  logic             load;
  logic             shift;
  logic             res_we;
  logic             res_eq;
  logic             res_ge;

  logic [digit-1:0] dig_a;
  logic [digit-1:0] dig_b;
  logic [digit-1:0] cmp_a;
  logic [digit-1:0] cmp_b;
  logic             dig_eq;
  logic             dig_ge;

  assign dig_a = a_q[width-1 -: digit];
  assign dig_b = b_q[width-1 -: digit];

`ifdef CMP_SERIAL_SIGNED_EN
  localparam logic [digit-1:0] msb_mask = digit'(1) << (digit - 1);

  logic first_run;

  // Flipping the sign bit of both top digits maps two's complement order onto unsigned order.
  assign first_run = (cnt_q == cnt_w'(n_dig - 1));
  assign cmp_a     = dig_a ^ (first_run ? msb_mask : '0);
  assign cmp_b     = dig_b ^ (first_run ? msb_mask : '0);
`else
  assign cmp_a = dig_a;
  assign cmp_b = dig_b;
`endif

  CmpEQGE #(
    .width (digit),
    .speed (speed)
  ) u_cmp (
    .A_i  (cmp_a),
    .B_i  (cmp_b),
    .EQ_o (dig_eq),
    .GE_o (dig_ge)
  );

  // Next state and datapath controls.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    res_we  = 1'b0;
    res_eq  = 1'b0;
    res_ge  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!dig_eq) begin
          res_we  = 1'b1;
          res_eq  = 1'b0;
          res_ge  = dig_ge;
          state_d = DONE;
        end else if (cnt_q == '0) begin
          res_we  = 1'b1;
          res_eq  = 1'b1;
          res_ge  = 1'b1;
          state_d = DONE;
        end else begin
          shift = 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, handshake flags and result register; flags are decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      EQ_o        <= 1'b0;
      GE_o        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_o  <= (state_d == IDLE);
      out_valid_o <= (state_d == DONE);
      busy_o      <= (state_d != IDLE);
      if (res_we) begin
        EQ_o <= res_eq;
        GE_o <= res_ge;
      end
      if (load) begin
        cnt_q <= cnt_w'(n_dig - 1);
      end else if (shift) begin
        cnt_q <= cnt_q - cnt_w'(1);
      end
    end
  end

  // Operand shift registers; the digit under test is always the top one.
  always_ff @(posedge clk_i) begin
    if (load) begin
      a_q <= A_i;
      b_q <= B_i;
    end else if (shift) begin
      a_q <= a_q << digit;
      b_q <= b_q << digit;
    end
  end

endmodule

// File: tb/tb_cmp_eqge_serial.sv
// Testbench for cmp_eqge_serial: digit 1, 8 and 32 instances run in lockstep against an arithmetic reference model.
// Honours CMP_SERIAL_SIGNED_EN in the model the same way the design does.
module tb_cmp_eqge_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  rdy;
  logic [2:0]  vld;
  logic [2:0]  eq;
  logic [2:0]  ge;
  logic [2:0]  busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_lat [3];
  logic last_eq  [3];
  logic last_ge  [3];

  always #5 clk = ~clk;

  cmp_eqge_serial #(.width(32), .digit(1), .speed(0)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
    .A_i(a), .B_i(b), .out_valid_o(vld[0]), .out_ready_i(out_ready),
    .EQ_o(eq[0]), .GE_o(ge[0]), .busy_o(busy[0]));

  cmp_eqge_serial #(.width(32), .digit(8), .speed(2)) u_d8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
    .A_i(a), .B_i(b), .out_valid_o(vld[1]), .out_ready_i(out_ready),
    .EQ_o(eq[1]), .GE_o(ge[1]), .busy_o(busy[1]));

  cmp_eqge_serial #(.width(32), .digit(32), .speed(1)) u_d32 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[2]),
    .A_i(a), .B_i(b), .out_valid_o(vld[2]), .out_ready_i(out_ready),
    .EQ_o(eq[2]), .GE_o(ge[2]), .busy_o(busy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dig_of(input int i);
    case (i)
      0:       return 1;
      1:       return 8;
      default: return 32;
    endcase
  endfunction

  // Cycles from accept to out_valid: 1 + index of the first differing digit from the MSB, or N if equal.
  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y, input int d);
    longint unsigned xv = 64'(x);
    longint unsigned yv = 64'(y);
    longint unsigned md = 64'd1 << d;
    int n = 32 / d;
    for (int i = 0; i < n; i++) begin
      int sh = 32 - d * (i + 1);
      if (((xv >> sh) % md) != ((yv >> sh) % md)) return i + 1;
    end
    return n;
  endfunction

  function automatic logic exp_ge(input logic [31:0] x, input logic [31:0] y);
`ifdef CMP_SERIAL_SIGNED_EN
    return $signed(x) >= $signed(y);
`else
    return x >= y;
`endif
  endfunction

  // One compare on all three instances with out_ready held high; ends with every instance back in IDLE.
  task automatic run_pair(input logic [31:0] x, input logic [31:0] y);
    int   k [3];
    logic seen [3];
    for (int i = 0; i < 3; i++) begin
      k[i]    = exp_lat(x, y, dig_of(i));
      seen[i] = 1'b0;
      check($sformatf("ready_d%0d", dig_of(i)), 32'(rdy[i]), 32'd1);
    end
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (vld[i] && !seen[i]) begin
          seen[i]     = 1'b1;
          last_lat[i] = c;
          last_eq[i]  = eq[i];
          last_ge[i]  = ge[i];
          check($sformatf("lat_d%0d a=%h b=%h", dig_of(i), x, y), 32'(c), 32'(k[i]));
          check($sformatf("eq_d%0d a=%h b=%h", dig_of(i), x, y), 32'(eq[i]), 32'(x == y));
          check($sformatf("ge_d%0d a=%h b=%h", dig_of(i), x, y), 32'(ge[i]), 32'(exp_ge(x, y)));
        end
      end
      if (seen[0] && seen[1] && seen[2]) break;
    end
    for (int i = 0; i < 3; i++) begin
      if (!seen[i]) check($sformatf("timeout_d%0d", dig_of(i)), 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    int          nv [3];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ready_d%0d", dig_of(i)), 32'(rdy[i]), 32'd1);
      check($sformatf("rst_valid_d%0d", dig_of(i)), 32'(vld[i]), 32'd0);
      check($sformatf("rst_eq_d%0d", dig_of(i)), 32'(eq[i]), 32'd0);
      check($sformatf("rst_ge_d%0d", dig_of(i)), 32'(ge[i]), 32'd0);
      check($sformatf("rst_busy_d%0d", dig_of(i)), 32'(busy[i]), 32'd0);
    end
    rst_n = 1'b1;

    // Directed cases with hand-derived numbers for the digit-8 instance.
    run_pair(32'h1234_5678, 32'h1234_5678);
    check("t1_lat", 32'(last_lat[1]), 32'd4);
    check("t1_eq", 32'(last_eq[1]), 32'd1);
    check("t1_ge", 32'(last_ge[1]), 32'd1);

    run_pair(32'h8000_0000, 32'h7FFF_FFFF);
    check("t2_lat", 32'(last_lat[1]), 32'd1);
    check("t2_eq", 32'(last_eq[1]), 32'd0);
`ifdef CMP_SERIAL_SIGNED_EN
    check("t2_ge", 32'(last_ge[1]), 32'd0);
`else
    check("t2_ge", 32'(last_ge[1]), 32'd1);
`endif

    run_pair(32'h0000_00FE, 32'h0000_00FF);
    check("t3_lat", 32'(last_lat[1]), 32'd4);
    check("t3_lat_d32", 32'(last_lat[2]), 32'd1);
    check("t3_eq", 32'(last_eq[1]), 32'd0);
    check("t3_ge", 32'(last_ge[1]), 32'd0);

    // Back-pressure: results held, no capture while operands keep arriving.
    out_ready = 1'b0;
    a         = 32'h0000_00FE;
    b         = 32'h0000_00FF;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    a = 32'hFFFF_FFF0;
    b = 32'h0000_0001;
    for (int c = 0; c < 40 && vld != 3'b111; c++) begin
      @(posedge clk);
      #1;
    end
    check("t4_all_valid", 32'(vld), 32'h7);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("t4_valid_d%0d", dig_of(i)), 32'(vld[i]), 32'd1);
        check($sformatf("t4_ready_d%0d", dig_of(i)), 32'(rdy[i]), 32'd0);
        check($sformatf("t4_busy_d%0d", dig_of(i)), 32'(busy[i]), 32'd1);
        check($sformatf("t4_eq_d%0d", dig_of(i)), 32'(eq[i]), 32'd0);
        check($sformatf("t4_ge_d%0d", dig_of(i)), 32'(ge[i]), 32'd0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_rel_ready_d%0d", dig_of(i)), 32'(rdy[i]), 32'd1);
      check($sformatf("t4_rel_valid_d%0d", dig_of(i)), 32'(vld[i]), 32'd0);
      check($sformatf("t4_rel_busy_d%0d", dig_of(i)), 32'(busy[i]), 32'd0);
    end

    // Reset in the second RUN cycle aborts the compare.
    run_pair(32'h5555_AAAA, 32'h5555_AAAA);
    a        = 32'hCAFE_F00D;
    b        = 32'hCAFE_F00D;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5_valid_d%0d", dig_of(i)), 32'(vld[i]), 32'd0);
      check($sformatf("t5_eq_d%0d", dig_of(i)), 32'(eq[i]), 32'd0);
      check($sformatf("t5_ge_d%0d", dig_of(i)), 32'(ge[i]), 32'd0);
      check($sformatf("t5_ready_d%0d", dig_of(i)), 32'(rdy[i]), 32'd1);
      nv[i] = 0;
    end
    repeat (40) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) nv[i] += int'(vld[i]);
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5_no_result_d%0d", dig_of(i)), 32'(nv[i]), 32'd0);
    end

    // Random pairs: a quarter equal, a quarter one bit apart, the rest independent.
    for (int n = 0; n < 2000; n++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ (32'd1 << $urandom_range(0, 31));
        default: y = $urandom;
      endcase
      run_pair(x, y);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
